cam_capture_rgb444: RTL and testbench

- Upstream stage of the dual-port frame buffer.
- Samples the OV7670 8-bit parallel bus in RGB444 mode, which sends two bytes per pixel.
- Assembles each pixel into 12 bits and generates its linear frame address.
- Issues single-cycle write strobes that drive the buffer write port (addr_in, data_in, regwrite) in the clk_w domain.
- Writes only complete frames, from start-of-frame onward, clipped to the configured resolution.

---
 rtl/cam_capture_rgb444_if.sv | 25 ++
 rtl/cam_capture_rgb444.sv | 140 ++++++++++++++
 tb/tb_cam_capture_rgb444.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_rgb444_if.sv
// Camera input bus and frame-buffer write port for the RGB444 capture stage.
interface cam_capture_rgb444_if #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 12
);
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr;
  logic          frame_done;

  // Capture block: consumes camera signals, drives the buffer write port.
  modport master (
    input  vsync, href, px_data,
    output mem_px_addr, mem_px_data, px_wr, frame_done
  );

  // Camera/buffer side: drives camera signals, consumes write strobes.
  modport slave (
    output vsync, href, px_data,
    input  mem_px_addr, mem_px_data, px_wr, frame_done
  );
endinterface

// File: rtl/cam_capture_rgb444.sv
// OV7670 RGB444 capture: pairs bytes into 12-bit pixels and writes whole,
// resolution-clipped frames into the frame buffer, starting only at SOF.
module cam_capture_rgb444 #(
  parameter int unsigned AW       = 15,
  parameter int unsigned DW       = 12,
  parameter int unsigned H_PIXELS = 160,
  parameter int unsigned V_LINES  = 120
) (
  input  logic                  clk_w,
  input  logic                  reset,
  cam_capture_rgb444_if.master  bus
);

  localparam int unsigned CW = $clog2(H_PIXELS + 1);
  localparam int unsigned RW = $clog2(V_LINES + 1);

  typedef enum logic [1:0] {
    WAIT_SOF  = 2'd0,
    LINE_IDLE = 2'd1,
    BYTE1     = 2'd2,
    BYTE2     = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          vsync_d;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] line_base;
  logic [3:0]    red_nib;

  logic sof_c;
  logic clr_c;
  logic latch_c;
  logic pix_c;
  logic eol_c;
  logic abort_c;
  logic in_win_c;

  assign sof_c    = vsync_d & ~bus.vsync;
  assign in_win_c = (col < CW'(H_PIXELS)) && (row < RW'(V_LINES));

  // State register.
  always_ff @(posedge clk_w or negedge reset) begin
    if (!reset) state <= WAIT_SOF;
    else        state <= state_nxt;
  end

  // Next-state logic; vsync high aborts any active frame before href is considered.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SOF: begin
        if (sof_c) state_nxt = LINE_IDLE;
      end
      LINE_IDLE: begin
        if (bus.vsync)     state_nxt = WAIT_SOF;
        else if (bus.href) state_nxt = BYTE2;
      end
      BYTE1: begin
        if (bus.vsync)     state_nxt = WAIT_SOF;
        else if (bus.href) state_nxt = BYTE2;
        else               state_nxt = LINE_IDLE;
      end
      BYTE2: begin
        if (bus.vsync)     state_nxt = WAIT_SOF;
        else if (bus.href) state_nxt = BYTE1;
        else               state_nxt = LINE_IDLE;
      end
      default: state_nxt = WAIT_SOF;
    endcase
  end

  // Action decode for the datapath registers.
  always_comb begin
    clr_c   = 1'b0;
    latch_c = 1'b0;
    pix_c   = 1'b0;
    eol_c   = 1'b0;
    abort_c = 1'b0;
    case (state)
      WAIT_SOF: begin
        clr_c = sof_c;
      end
      LINE_IDLE: begin
        abort_c = bus.vsync;
        latch_c = ~bus.vsync & bus.href;
      end
      BYTE1: begin
        abort_c = bus.vsync;
        latch_c = ~bus.vsync & bus.href;
        eol_c   = ~bus.vsync & ~bus.href;
      end
      BYTE2: begin
        abort_c = bus.vsync;
        pix_c   = ~bus.vsync & bus.href;
        eol_c   = ~bus.vsync & ~bus.href;
      end
      default: ;
    endcase
  end

  // Datapath: pixel assembly, row/column tracking and registered write port.
  always_ff @(posedge clk_w or negedge reset) begin
    if (!reset) begin
      vsync_d         <= 1'b0;
      col             <= '0;
      row             <= '0;
      line_base       <= '0;
      red_nib         <= '0;
      bus.mem_px_addr <= '0;
      bus.mem_px_data <= '0;
      bus.px_wr       <= 1'b0;
      bus.frame_done  <= 1'b0;
    end else begin
      vsync_d        <= bus.vsync;
      bus.frame_done <= abort_c;
      bus.px_wr      <= pix_c & in_win_c;
      if (latch_c) red_nib <= bus.px_data[3:0];
      if (pix_c && in_win_c) begin
        bus.mem_px_addr <= line_base + AW'(col);
        bus.mem_px_data <= DW'({red_nib, bus.px_data});
      end
      if (clr_c) begin
        col       <= '0;
        row       <= '0;
        line_base <= '0;
      end else if (eol_c) begin
        col <= '0;
        if (row < RW'(V_LINES)) begin
          row       <= row + 1'b1;
          line_base <= line_base + AW'(H_PIXELS);
        end
      end else if (pix_c && (col < CW'(H_PIXELS))) begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Self-checking bench for cam_capture_rgb444 against a frame-level reference model.
module tb_cam_capture_rgb444;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 12;
  localparam int unsigned H  = 160;
  localparam int unsigned V  = 120;

  logic clk_w = 1'b0;
  logic reset;

  always #5 clk_w = ~clk_w;

  cam_capture_rgb444_if #(.AW(AW), .DW(DW)) bus ();

  cam_capture_rgb444 #(.AW(AW), .DW(DW), .H_PIXELS(H), .V_LINES(V)) dut (
    .clk_w (clk_w),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  int model_row = 0;

  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  logic [7:0]    line_q[$];

  // Record every write strobe and frame_done pulse mid-cycle.
  always @(negedge clk_w) begin
    if (bus.px_wr === 1'b1) begin
      obs_addr.push_back(bus.mem_px_addr);
      obs_data.push_back(bus.mem_px_data);
    end
    if (bus.frame_done === 1'b1) fd_cnt++;
  end

  task automatic cyc(input logic v, input logic h, input logic [7:0] d);
    bus.vsync   = v;
    bus.href    = h;
    bus.px_data = d;
    @(posedge clk_w);
    #1;
  endtask

  task automatic clear();
    obs_addr.delete(); obs_data.delete();
    exp_addr.delete(); exp_data.delete();
    fd_cnt = 0;
  endtask

  task automatic sof();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    model_row = 0;
  endtask

  task automatic end_frame();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic rand_line(input int n);
    line_q.delete();
    for (int i = 0; i < n; i++) line_q.push_back(8'($urandom));
  endtask

  // Reference: pixel p of line r is written at r*H+p when inside the window.
  task automatic model_line();
    for (int p = 0; p < line_q.size() / 2; p++) begin
      if (model_row < int'(V) && p < int'(H)) begin
        exp_addr.push_back(AW'(model_row * int'(H) + p));
        exp_data.push_back({line_q[2*p][3:0], line_q[2*p+1]});
      end
    end
    model_row++;
  endtask

  task automatic send_line(input int gap);
    foreach (line_q[i]) cyc(1'b0, 1'b1, line_q[i]);
    repeat (gap) cyc(1'b0, 1'b0, 8'h00);
    model_line();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.vsync = 1'b0; bus.href = 1'b0; bus.px_data = 8'h00;
    #7;
    checks++; if (bus.px_wr !== 1'b0) begin errors++; $display("FAIL reset_px_wr: got %b want 0", bus.px_wr); end
    checks++; if (bus.mem_px_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h want 0", bus.mem_px_addr); end
    checks++; if (bus.mem_px_data !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", bus.mem_px_data); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
    #20;
    reset = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_single_frame();
    int bad;
    clear();
    sof();
    line_q.delete();
    repeat (H) begin line_q.push_back(8'h0A); line_q.push_back(8'hBC); end
    repeat (V) send_line(2);
    end_frame();
    checks++; if (obs_addr.size() !== 19200) begin errors++; $display("FAIL frame_count: got %0d want 19200", obs_addr.size()); end
    bad = -1;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
      if (bad < 0 && (obs_addr[i] !== exp_addr[i] || obs_data[i] !== 12'hABC)) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL frame_seq: idx %0d got %0h/%0h want %0h/abc", bad, obs_addr[bad], obs_data[bad], exp_addr[bad]); end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt); end
  endtask

  task automatic test_byte_order();
    clear();
    sof();
    cyc(1'b0, 1'b1, 8'h05);
    checks++; if (bus.px_wr !== 1'b0) begin errors++; $display("FAIL order_b0_wr: got %b want 0", bus.px_wr); end
    cyc(1'b0, 1'b1, 8'h6F);
    checks++; if (bus.px_wr !== 1'b1 || bus.mem_px_addr !== 15'd0 || bus.mem_px_data !== 12'h56F) begin
      errors++; $display("FAIL order_px0: got wr=%b addr=%0h data=%0h want 1/0/56f", bus.px_wr, bus.mem_px_addr, bus.mem_px_data); end
    cyc(1'b0, 1'b1, 8'h0F);
    checks++; if (bus.px_wr !== 1'b0 || bus.mem_px_addr !== 15'd0 || bus.mem_px_data !== 12'h56F) begin
      errors++; $display("FAIL order_hold: got wr=%b addr=%0h data=%0h want 0/0/56f", bus.px_wr, bus.mem_px_addr, bus.mem_px_data); end
    cyc(1'b0, 1'b1, 8'h00);
    checks++; if (bus.px_wr !== 1'b1 || bus.mem_px_addr !== 15'd1 || bus.mem_px_data !== 12'hF00) begin
      errors++; $display("FAIL order_px1: got wr=%b addr=%0h data=%0h want 1/1/f00", bus.px_wr, bus.mem_px_addr, bus.mem_px_data); end
    cyc(1'b0, 1'b0, 8'h00);
    checks++; if (bus.px_wr !== 1'b0) begin errors++; $display("FAIL order_after_wr: got %b want 0", bus.px_wr); end
    end_frame();
  endtask

  task automatic test_clipping();
    int bad;
    clear();
    sof();
    rand_line(400); send_line(2);
    rand_line(4);   send_line(2);
    end_frame();
    checks++; if (obs_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL clip_h_count: got %0d want %0d", obs_addr.size(), exp_addr.size()); end
    bad = -1;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
      if (bad < 0 && (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL clip_h_seq: idx %0d got %0h/%0h want %0h/%0h", bad, obs_addr[bad], obs_data[bad], exp_addr[bad], exp_data[bad]); end
    if (obs_addr.size() > 160) begin
      checks++; if (obs_addr[160] !== 15'd160) begin errors++; $display("FAIL clip_next_line: got %0d want 160", obs_addr[160]); end
    end
    clear();
    sof();
    repeat (130) begin rand_line(2); send_line(1); end
    end_frame();
    checks++; if (obs_addr.size() !== 120) begin errors++; $display("FAIL clip_v_count: got %0d want 120", obs_addr.size()); end
    bad = -1;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
      if (bad < 0 && (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL clip_v_seq: idx %0d got %0h/%0h want %0h/%0h", bad, obs_addr[bad], obs_data[bad], exp_addr[bad], exp_data[bad]); end
  endtask

  task automatic test_short_odd();
    int bad;
    clear();
    sof();
    rand_line(7); send_line(2);
    rand_line(2); send_line(2);
    end_frame();
    checks++; if (obs_addr.size() !== 4) begin errors++; $display("FAIL short_count: got %0d want 4", obs_addr.size()); end
    bad = -1;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
      if (bad < 0 && (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL short_seq: idx %0d got %0h/%0h want %0h/%0h", bad, obs_addr[bad], obs_data[bad], exp_addr[bad], exp_data[bad]); end
    if (obs_addr.size() > 3) begin
      checks++; if (obs_addr[3] !== 15'd160) begin errors++; $display("FAIL short_next_line: got %0d want 160", obs_addr[3]); end
    end
  endtask

  task automatic test_mid_vsync();
    int bad;
    clear();
    sof();
    rand_line(100);
    foreach (line_q[i]) cyc(1'b0, 1'b1, line_q[i]);
    model_line();
    cyc(1'b0, 1'b1, 8'($urandom));
    cyc(1'b1, 1'b1, 8'($urandom));
    repeat (6) cyc(1'b1, 1'($urandom), 8'($urandom));
    checks++; if (obs_addr.size() !== 50) begin errors++; $display("FAIL midv_count: got %0d want 50", obs_addr.size()); end
    bad = -1;
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
      if (bad < 0 && (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL midv_seq: idx %0d got %0h/%0h want %0h/%0h", bad, obs_addr[bad], obs_data[bad], exp_addr[bad], exp_data[bad]); end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL midv_frame_done: got %0d want 1", fd_cnt); end
  endtask

  task automatic test_async_reset();
    clear();
    sof();
    repeat (9) begin rand_line(320); send_line(2); end
    rand_line(22);
    foreach (line_q[i]) cyc(1'b0, 1'b1, line_q[i]);
    checks++; if (bus.px_wr !== 1'b1 || bus.mem_px_addr !== 15'd1450) begin
      errors++; $display("FAIL arst_pre: got wr=%b addr=%0d want 1/1450", bus.px_wr, bus.mem_px_addr); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.px_wr !== 1'b0 || bus.mem_px_addr !== '0 || bus.mem_px_data !== '0 || bus.frame_done !== 1'b0) begin
      errors++; $display("FAIL arst_clear: got wr=%b addr=%0h data=%0h fd=%b want all 0", bus.px_wr, bus.mem_px_addr, bus.mem_px_data, bus.frame_done); end
    repeat (3) cyc(1'b0, 1'($urandom), 8'($urandom));
    reset = 1'b1;
    clear();
    repeat (4) begin
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 8'($urandom));
      cyc(1'b0, 1'b0, 8'h00);
    end
    checks++; if (obs_addr.size() !== 0) begin errors++; $display("FAIL nosof_writes: got %0d want 0", obs_addr.size()); end
    checks++; if (fd_cnt !== 0) begin errors++; $display("FAIL nosof_frame_done: got %0d want 0", fd_cnt); end
    sof();
    rand_line(4); send_line(2);
    end_frame();
    checks++; if (obs_addr.size() !== 2 || obs_addr[0] !== 15'd0 || obs_data[0] !== exp_data[0]) begin
      errors++; $display("FAIL resume_first: got n=%0d addr=%0h data=%0h want 2/0/%0h", obs_addr.size(), obs_addr[0], obs_data[0], exp_data[0]); end
  endtask

  task automatic test_random_frames();
    int bad;
    for (int f = 0; f < 3; f++) begin
      clear();
      sof();
      repeat ($urandom_range(1, 5)) begin
        rand_line(int'($urandom_range(1, 340)));
        send_line(int'($urandom_range(1, 3)));
      end
      end_frame();
      checks++; if (obs_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", f, obs_addr.size(), exp_addr.size()); end
      bad = -1;
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
        if (bad < 0 && (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])) bad = i;
      checks++; if (bad >= 0) begin errors++; $display("FAIL rand%0d_seq: idx %0d got %0h/%0h want %0h/%0h", f, bad, obs_addr[bad], obs_data[bad], exp_addr[bad], exp_data[bad]); end
      checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL rand%0d_frame_done: got %0d want 1", f, fd_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_byte_order();
    test_clipping();
    test_short_odd();
    test_mid_vsync();
    test_async_reset();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound the whole run in case the bench stalls.
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
